mlp_argmax_unit: RTL
====================

// Module: mlp_argmax_unit
// PURPOSE
//  Downstream of the MLP top: snoops the y_buf write port (10 FP32 logits/image, byte addr stride 4),
//  latches logits, and on the done pulse scans them sequentially to produce the predicted class.
//  Result is held on a valid/ready handshake toward the host/LED/UART consumer.
// PARAMETERS
//  NUM_CLASS    10   logits per image
//  DATA_WIDTH   32   IEEE-754 single logit width
//  ADDR_WIDTH   6    y_buf byte-address width, $clog2(NUM_CLASS*4)
//  ADDR_STRIDE  4    byte step between consecutive logits
// PORTS
//  clk            in   1            system clock
//  rst            in   1            synchronous reset, active-high
//  y_buf_en_i     in   1            y_buf enable (snooped)
//  y_buf_wr_en_i  in   1            y_buf write enable (snooped)
//  y_buf_addr_i   in   ADDR_WIDTH   y_buf byte address
//  y_buf_data_i   in   DATA_WIDTH   logit value
//  done_i         in   1            1-cycle pulse: all logits of the image written
//  class_o        out  4            argmax index, 0..NUM_CLASS-1
//  max_val_o      out  DATA_WIDTH   winning logit
//  class_valid_o  out  1            result valid
//  class_ready_i  in   1            consumer accepts result
//  err_o          out  1            sticky protocol error
// BEHAVIOUR
//  Reset: state=IDLE; class_o=0, max_val_o=0, class_valid_o=0, err_o=0; logit regs and written mask cleared.
//  Capture: en&wr_en, addr%4==0, addr/4<NUM_CLASS -> logit[addr/4]<=data, mask bit set. Rewrite overwrites.
//  Misaligned or out-of-range write -> dropped, err_o<=1 (sticky until rst).
//  FSM: IDLE -(first valid write)-> COLLECT -(done_i)-> SCAN -(idx==NUM_CLASS-1)-> HOLD -(valid&ready)-> IDLE.
//   done_i in IDLE also enters SCAN (unwritten slots read as 0.0). done_i with mask != all-ones -> err_o<=1.
//  SCAN: one logit/cycle, idx 0..NUM_CLASS-1; best<=logit[0] at idx 0, replaced only if strictly greater.
//   Latency done_i -> class_valid_o = NUM_CLASS+1 cycles (11 default).
//  Compare: FP32 total order via key = sign ? ~x : x|0x8000_0000; -0.0 == +0.0 (treated equal).
//   Any NaN (exp=0xFF, mant!=0) ranks below all numbers; ties -> lowest index wins.
//  HOLD: class_o/max_val_o stable while class_valid_o=1 and !class_ready_i; accept on valid&ready, valid drops next cycle.
//  Writes during SCAN/HOLD: dropped, err_o<=1. Writes in the accept cycle: dropped (next image starts after IDLE).
//  Accept clears mask and logit regs. done_i during SCAN/HOLD: ignored, err_o<=1.
//  rst mid-SCAN/HOLD: immediate return to reset state next edge, result discarded.
// CONFIGURATION
//  MLP_ARGMAX_TOP2_EN defined: adds out class2_o[3:0] = runner-up index (same compare/tie rules,
//   tracked in the same SCAN pass, no extra latency); reset 0; valid with class_valid_o.
//  Undefined: no class2_o port, no runner-up registers.
// STRUCTURE
//  mlp_pkg: NUM_CLASS, ADDR_STRIDE, FSM state enum (IDLE/COLLECT/SCAN/HOLD), function fp32_key().
//  Sub-module fp32_gt: combinational a>b on FP32 with NaN/±0 rules; one instance (two with TOP2).
// TESTING
//  1. Write logits 0..9 = 1.0,2.0,..,10.0 at addr 0,4,..,36; done -> after 11 cyc class_o=9, max=0x41200000.
//  2. All logits 3.5 (0x40600000) -> class_o=0 (tie, lowest index); err_o=0.
//  3. Negatives: logit[4]=-0.5, rest -2.0; plus logit[7]=NaN -> class_o=4, max=0xBF000000.
//  4. Hold class_ready_i=0 20 cycles -> outputs stable, valid high; ready=1 -> valid 0 next cycle, state IDLE.
//  5. Write to addr 40 and addr 6; done with slot 3 unwritten -> err_o=1, sticky until rst.
//  6. Assert rst during SCAN -> next cycle all outputs 0; fresh image then gives correct class.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared constants, FSM state type and FP32 ordering helpers for the MLP argmax unit.
package mlp_pkg;

  localparam int unsigned NUM_CLASS   = 10;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH  = 6;
  localparam int unsigned ADDR_STRIDE = 4;
  localparam int unsigned IDX_WIDTH   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StScan,
    StHold
  } state_e;

  // Maps FP32 onto an unsigned key whose integer order is the numeric order.
  function automatic logic [DATA_WIDTH-1:0] fp32_key(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] v;
    v = (x[30:0] == 31'h0) ? 32'h0000_0000 : x;  // fold -0.0 onto +0.0
    return v[31] ? ~v : (v | 32'h8000_0000);
  endfunction

  function automatic logic fp32_is_nan(input logic [DATA_WIDTH-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational strict a > b on FP32; NaN ranks below every number, -0.0 equals +0.0.
module fp32_gt
  import mlp_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  gt_o
);

  logic a_nan, b_nan;

  assign a_nan = fp32_is_nan(a_i);
  assign b_nan = fp32_is_nan(b_i);
  assign gt_o  = !a_nan && (b_nan || (fp32_key(a_i) > fp32_key(b_i)));

endmodule

// File: rtl/mlp_argmax_unit.sv
// Snoops y_buf logit writes, scans them after done_i and holds the argmax on a valid/ready port.
// Define MLP_ARGMAX_TOP2_EN to add the runner-up index output class2_o.
module mlp_argmax_unit
  import mlp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  y_buf_en_i,
  input  logic                  y_buf_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] y_buf_addr_i,
  input  logic [DATA_WIDTH-1:0] y_buf_data_i,
  input  logic                  done_i,
  output logic [IDX_WIDTH-1:0]  class_o,
  output logic [DATA_WIDTH-1:0] max_val_o,
  output logic                  class_valid_o,
  input  logic                  class_ready_i,
`ifdef MLP_ARGMAX_TOP2_EN
  output logic [IDX_WIDTH-1:0]  class2_o,
`endif
  output logic                  err_o
);

  localparam logic [NUM_CLASS-1:0] MaskFull = '1;
  localparam logic [IDX_WIDTH-1:0] LastIdx  = IDX_WIDTH'(NUM_CLASS - 1);

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  err_q, err_d;
  logic [NUM_CLASS-1:0]  mask_q;
  logic [DATA_WIDTH-1:0] logit_q [NUM_CLASS];
  logic [DATA_WIDTH-1:0] best_val_q, best_val_d;
  logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;

  logic                  wr_req, wr_ok, capture, clear;
  logic [ADDR_WIDTH-1:0] slot;
  logic [IDX_WIDTH-1:0]  slot_idx;
  logic [DATA_WIDTH-1:0] cur;
  logic                  cur_gt_best;

  assign wr_req   = y_buf_en_i & y_buf_wr_en_i;
  assign slot     = y_buf_addr_i / ADDR_WIDTH'(ADDR_STRIDE);
  assign slot_idx = slot[IDX_WIDTH-1:0];
  assign wr_ok    = ((y_buf_addr_i % ADDR_WIDTH'(ADDR_STRIDE)) == '0) &&
                    (slot < ADDR_WIDTH'(NUM_CLASS));
  assign cur      = logit_q[idx_q];

  fp32_gt u_gt_best (
    .a_i  (cur),
    .b_i  (best_val_q),
    .gt_o (cur_gt_best)
  );

`ifdef MLP_ARGMAX_TOP2_EN
  logic [DATA_WIDTH-1:0] sec_val_q, sec_val_d;
  logic [IDX_WIDTH-1:0]  sec_idx_q, sec_idx_d;
  logic                  sec_set_q, sec_set_d;
  logic                  cur_gt_sec;

  fp32_gt u_gt_sec (
    .a_i  (cur),
    .b_i  (sec_val_q),
    .gt_o (cur_gt_sec)
  );

  assign class2_o = sec_idx_q;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    capture    = 1'b0;
    clear      = 1'b0;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
`ifdef MLP_ARGMAX_TOP2_EN
    sec_val_d  = sec_val_q;
    sec_idx_d  = sec_idx_q;
    sec_set_d  = sec_set_q;
`endif
    unique case (state_q)
      StIdle, StCollect: begin
        if (wr_req) begin
          if (wr_ok) begin
            capture = 1'b1;
            state_d = StCollect;
          end else begin
            err_d = 1'b1;
          end
        end
        if (done_i) begin
          state_d = StScan;
          idx_d   = '0;
          if (mask_q != MaskFull) err_d = 1'b1;
        end
      end
      StScan: begin
        if (wr_req || done_i) err_d = 1'b1;
        if (idx_q == '0) begin
          best_val_d = cur;
          best_idx_d = idx_q;
`ifdef MLP_ARGMAX_TOP2_EN
          sec_set_d  = 1'b0;
`endif
        end else if (cur_gt_best) begin
          best_val_d = cur;
          best_idx_d = idx_q;
`ifdef MLP_ARGMAX_TOP2_EN
          sec_val_d  = best_val_q;
          sec_idx_d  = best_idx_q;
          sec_set_d  = 1'b1;
        end else if (!sec_set_q || cur_gt_sec) begin
          sec_val_d  = cur;
          sec_idx_d  = idx_q;
          sec_set_d  = 1'b1;
`endif
        end
        if (idx_q == LastIdx) state_d = StHold;
        else idx_d = idx_q + 1'b1;
      end
      StHold: begin
        // The accept cycle silently drops writes; the next image starts from idle.
        if (class_ready_i) begin
          state_d = StIdle;
          clear   = 1'b1;
        end else if (wr_req || done_i) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      err_q      <= 1'b0;
      best_val_q <= '0;
      best_idx_q <= '0;
      mask_q     <= '0;
      for (int i = 0; i < NUM_CLASS; i++) logit_q[i] <= '0;
`ifdef MLP_ARGMAX_TOP2_EN
      sec_val_q  <= '0;
      sec_idx_q  <= '0;
      sec_set_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
`ifdef MLP_ARGMAX_TOP2_EN
      sec_val_q  <= sec_val_d;
      sec_idx_q  <= sec_idx_d;
      sec_set_q  <= sec_set_d;
`endif
      if (clear) begin
        mask_q <= '0;
        for (int i = 0; i < NUM_CLASS; i++) logit_q[i] <= '0;
      end else if (capture) begin
        mask_q[slot_idx]  <= 1'b1;
        logit_q[slot_idx] <= y_buf_data_i;
      end
    end
  end

  assign class_o       = best_idx_q;
  assign max_val_o     = best_val_q;
  assign class_valid_o = (state_q == StHold);
  assign err_o         = err_q;

endmodule
